// File: rtl/mic_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mic_ctrl_pkg
// Shared definitions for the microphone cross-correlation control slice.
//   - state_t      : xcorr_scheduler FSM state encoding
//   - LAG_W_DEF    : default width of a lag result
//   - LAG_SUM_W    : width of the 4-tap lag sum at the default lag width
//   - lag_sum_w()  : 4-tap sum width for an arbitrary lag width (LAG_W + 2)
// No ports (package).
// ----------------------------------------------------------------------------
package mic_ctrl_pkg;

  localparam int LAG_W_DEF = 6;

  // Four LAG_W-bit samples plus the rounding constant fit in LAG_W + 2 bits.
  localparam int LAG_SUM_W = LAG_W_DEF + 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_CAPT  = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  function automatic int lag_sum_w(input int lag_w);
    return lag_w + 2;
  endfunction

endpackage

// File: rtl/lag_avg4.sv
// ----------------------------------------------------------------------------
// lag_avg4
// 4-tap moving average of lag results with round-half-up:
//   avg = (h0 + h1 + h2 + h3 + 2) >> 2
// The average is computed from the history *including* the sample being
// written this cycle, so the caller can register it on the same edge.
// The first sample after clr_fill loads all four taps, avoiding warm-up bias.
// Only built into xcorr_scheduler when XCORR_LAG_AVG_EN is defined.
//
// Ports:
//   clk_60MHz  in  clock
//   rst_n      in  asynchronous active-low reset (history and fill flag to 0)
//   clr_fill   in  forget the fill state; next sample reloads all taps
//   sample_en  in  push 'sample' into the history this cycle
//   sample     in  [LAG_W-1:0] new lag result
//   avg        out [LAG_W-1:0] rounded average of the post-update history
// ----------------------------------------------------------------------------
module lag_avg4
  import mic_ctrl_pkg::*;
#(
  parameter int LAG_W = LAG_W_DEF
) (
  input  logic             clk_60MHz,
  input  logic             rst_n,
  input  logic             clr_fill,
  input  logic             sample_en,
  input  logic [LAG_W-1:0] sample,
  output logic [LAG_W-1:0] avg
);

  localparam int SUM_W = lag_sum_w(LAG_W);

  logic [LAG_W-1:0] hist_reg  [4];
  logic [LAG_W-1:0] hist_next [4];
  logic             fill_reg;
  logic [SUM_W-1:0] sum;

  always_comb begin
    for (int i = 0; i < 4; i++) hist_next[i] = hist_reg[i];
    if (sample_en) begin
      if (!fill_reg) begin
        for (int i = 0; i < 4; i++) hist_next[i] = sample;
      end else begin
        hist_next[0] = sample;
        for (int i = 1; i < 4; i++) hist_next[i] = hist_reg[i-1];
      end
    end
  end

  // Seed with 2 so the final shift rounds half up.
  always_comb begin
    sum = SUM_W'(2);
    for (int i = 0; i < 4; i++) sum = sum + SUM_W'(hist_next[i]);
  end

  assign avg = sum[SUM_W-1:2];

  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist_reg[i] <= '0;
      fill_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) hist_reg[i] <= hist_next[i];
      if (clr_fill)       fill_reg <= 1'b0;
      else if (sample_en) fill_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/xcorr_scheduler.sv
// ----------------------------------------------------------------------------
// xcorr_scheduler
// Paces xcorr_start pulses into the cross-correlation datapath at a
// programmable frame period, waits for each run to finish, captures the lag
// result and reports a sticky watchdog error for runs that never finish.
//
// Optional feature macro: XCORR_LAG_AVG_EN
//   defined     -> lag_out is a 4-tap rounded moving average (lag_avg4)
//   not defined -> lag_out is the raw captured lag; no history registers
//   Output timing is identical in both builds.
//
// Ports:
//   clk_60MHz    in  the only clock
//   rst_n        in  asynchronous active-low reset
//   arm_en       in  run enable from the pad (asynchronous, synchronized here)
//   period_cfg   in  [PERIOD_W-1:0] cycles from one start to the next
//   err_clr      in  clears timeout_err (a simultaneous timeout wins)
//   xcorr_done   in  1-cycle pulse, lag_diff_in valid (honoured only in RUN)
//   lag_diff_in  in  [LAG_W-1:0] unsigned lag result
//   xcorr_start  out 1-cycle start pulse to the datapath (registered)
//   lag_out      out [LAG_W-1:0] latest result, raw or filtered
//   lag_valid    out 1-cycle pulse when lag_out updates
//   busy         out high whenever the FSM is not IDLE (registered)
//   timeout_err  out sticky watchdog flag
// ----------------------------------------------------------------------------
module xcorr_scheduler
  import mic_ctrl_pkg::*;
#(
  parameter int LAG_W       = LAG_W_DEF,
  parameter int PERIOD_W    = 20,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                clk_60MHz,
  input  logic                rst_n,
  input  logic                arm_en,
  input  logic [PERIOD_W-1:0] period_cfg,
  input  logic                err_clr,
  input  logic                xcorr_done,
  input  logic [LAG_W-1:0]    lag_diff_in,
  output logic                xcorr_start,
  output logic [LAG_W-1:0]    lag_out,
  output logic                lag_valid,
  output logic                busy,
  output logic                timeout_err
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic                arm_meta_reg;
  logic                arm_s_reg;
  state_t              state_reg, state_next;
  logic [PERIOD_W-1:0] period_cnt_reg, period_cnt_next, period_dec;
  logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
  logic [LAG_W-1:0]    lag_cap_reg, lag_cap_next;
  logic [LAG_W-1:0]    lag_new;
  logic                timeout_set;
  logic                xcorr_start_reg, busy_reg, lag_valid_reg, timeout_err_reg;
  logic [LAG_W-1:0]    lag_out_reg;

  // Two-flop synchronizer for the pad enable.
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      arm_meta_reg <= 1'b0;
      arm_s_reg    <= 1'b0;
    end else begin
      arm_meta_reg <= arm_en;
      arm_s_reg    <= arm_meta_reg;
    end
  end

  assign period_dec = (period_cnt_reg == '0) ? '0 : period_cnt_reg - PERIOD_W'(1);

  always_comb begin
    state_next      = state_reg;
    period_cnt_next = period_cnt_reg;
    to_cnt_next     = to_cnt_reg;
    lag_cap_next    = lag_cap_reg;
    timeout_set     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (arm_s_reg) state_next = ST_START;
      end
      ST_START: begin
        period_cnt_next = (period_cfg == '0) ? '0 : period_cfg - PERIOD_W'(1);
        to_cnt_next     = '0;
        state_next      = ST_RUN;
      end
      ST_RUN: begin
        period_cnt_next = period_dec;
        to_cnt_next     = to_cnt_reg + TO_W'(1);
        // A done arriving on the last allowed cycle still counts as success.
        if (xcorr_done) begin
          lag_cap_next = lag_diff_in;
          state_next   = ST_CAPT;
        end else if (to_cnt_reg == TO_LAST) begin
          timeout_set = 1'b1;
          state_next  = ST_WAIT;
        end
      end
      ST_CAPT: begin
        period_cnt_next = period_dec;
        state_next      = ST_WAIT;
      end
      ST_WAIT: begin
        period_cnt_next = period_dec;
        // The counter was loaded with period-1 in START, so it reaches zero on
        // this edge when it reads 1 now; that places the next START exactly
        // period_cfg cycles after the previous one.
        if (!arm_s_reg)                         state_next = ST_IDLE;
        else if (period_cnt_reg <= PERIOD_W'(1)) state_next = ST_START;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef XCORR_LAG_AVG_EN
  lag_avg4 #(
    .LAG_W (LAG_W)
  ) u_lag_avg4 (
    .clk_60MHz (clk_60MHz),
    .rst_n     (rst_n),
    .clr_fill  (state_reg == ST_IDLE),
    .sample_en (state_reg == ST_CAPT),
    .sample    (lag_cap_reg),
    .avg       (lag_new)
  );
`else
  assign lag_new = lag_cap_reg;
`endif

  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      period_cnt_reg  <= '0;
      to_cnt_reg      <= '0;
      lag_cap_reg     <= '0;
      xcorr_start_reg <= 1'b0;
      busy_reg        <= 1'b0;
      lag_valid_reg   <= 1'b0;
      lag_out_reg     <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      period_cnt_reg  <= period_cnt_next;
      to_cnt_reg      <= to_cnt_next;
      lag_cap_reg     <= lag_cap_next;
      xcorr_start_reg <= (state_next == ST_START);
      busy_reg        <= (state_next != ST_IDLE);
      lag_valid_reg   <= (state_reg == ST_CAPT);
      if (state_reg == ST_CAPT) lag_out_reg <= lag_new;
      if (timeout_set)  timeout_err_reg <= 1'b1;
      else if (err_clr) timeout_err_reg <= 1'b0;
    end
  end

  assign xcorr_start = xcorr_start_reg;
  assign busy        = busy_reg;
  assign lag_valid   = lag_valid_reg;
  assign lag_out     = lag_out_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_xcorr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_xcorr_scheduler
// Directed bench for xcorr_scheduler (TIMEOUT_CYC = 64). A table of capture
// vectors drives the periodic-run path; hand-written sequences cover timeout,
// err_clr priority, back-to-back runs, disarm mid-run and reset mid-run.
// Expected lag values follow XCORR_LAG_AVG_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_xcorr_scheduler;

  localparam int LAG_W       = 6;
  localparam int PERIOD_W    = 20;
  localparam int TIMEOUT_CYC = 64;

  logic                clk_60MHz   = 1'b0;
  logic                rst_n       = 1'b0;
  logic                arm_en      = 1'b0;
  logic [PERIOD_W-1:0] period_cfg  = '0;
  logic                err_clr     = 1'b0;
  logic                xcorr_done  = 1'b0;
  logic [LAG_W-1:0]    lag_diff_in = '0;
  logic                xcorr_start;
  logic [LAG_W-1:0]    lag_out;
  logic                lag_valid;
  logic                busy;
  logic                timeout_err;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  typedef struct {
    int dly;      // cycles from START to driving done
    int lag;      // lag_diff_in value
    int exp_raw;  // lag_out without the filter
    int exp_avg;  // lag_out with the 4-tap filter
    int exp_gap;  // cycles since previous START (first: since arm_en rise)
  } vec_t;

  vec_t vecs [5];

  xcorr_scheduler #(
    .LAG_W       (LAG_W),
    .PERIOD_W    (PERIOD_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_60MHz   (clk_60MHz),
    .rst_n       (rst_n),
    .arm_en      (arm_en),
    .period_cfg  (period_cfg),
    .err_clr     (err_clr),
    .xcorr_done  (xcorr_done),
    .lag_diff_in (lag_diff_in),
    .xcorr_start (xcorr_start),
    .lag_out     (lag_out),
    .lag_valid   (lag_valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #8 clk_60MHz = ~clk_60MHz;
  always @(posedge clk_60MHz) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_60MHz);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("  ok %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  function automatic int pick(input int raw, input int avg);
`ifdef XCORR_LAG_AVG_EN
    return avg;
`else
    return raw;
`endif
  endfunction

  task automatic wait_start(input int limit, output int waited);
    waited = 0;
    while (xcorr_start !== 1'b1 && waited < limit) begin
      tick();
      waited++;
    end
    if (xcorr_start !== 1'b1) begin
      n_vec++;
      n_miss++;
      $display("FAIL start_wait: xcorr_start still low after %0d cycles, required 1", limit);
    end
  endtask

  // Drive done for one cycle; returns in the CAPT cycle.
  task automatic pulse_done(input int lag);
    xcorr_done  = 1'b1;
    lag_diff_in = LAG_W'(lag);
    tick();
    xcorr_done  = 1'b0;
    lag_diff_in = '0;
  endtask

  initial begin
    int s_prev;
    int w;
    int seen;

    vecs[0] = '{dly: 10, lag: 20, exp_raw: 20, exp_avg: 20, exp_gap: 3};
    vecs[1] = '{dly: 10, lag: 4,  exp_raw: 4,  exp_avg: 16, exp_gap: 50};
    vecs[2] = '{dly: 10, lag: 4,  exp_raw: 4,  exp_avg: 12, exp_gap: 50};
    vecs[3] = '{dly: 10, lag: 4,  exp_raw: 4,  exp_avg: 8,  exp_gap: 50};
    vecs[4] = '{dly: 10, lag: 4,  exp_raw: 4,  exp_avg: 4,  exp_gap: 50};

    // Reset state
    repeat (3) tick();
    check("rst xcorr_start", xcorr_start, 0);
    check("rst busy", busy, 0);
    check("rst lag_out", lag_out, 0);
    check("rst lag_valid", lag_valid, 0);
    check("rst timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    tick();
    check("idle busy", busy, 0);

    // Periodic runs, done 10 cycles after each start
    period_cfg = PERIOD_W'(50);
    arm_en     = 1'b1;
    s_prev     = cyc;
    for (int i = 0; i < 5; i++) begin
      wait_start(80, w);
      check($sformatf("v%0d start gap", i), cyc - s_prev, vecs[i].exp_gap);
      s_prev = cyc;
      repeat (vecs[i].dly) tick();
      pulse_done(vecs[i].lag);
      check($sformatf("v%0d valid 1 edge", i), lag_valid, 0);
      tick();
      check($sformatf("v%0d valid 2 edges", i), lag_valid, 1);
      check($sformatf("v%0d lag_out", i), lag_out, pick(vecs[i].exp_raw, vecs[i].exp_avg));
    end

    // Timeout: no done for 64 RUN cycles
    period_cfg = PERIOD_W'(100);
    wait_start(80, w);
    check("to start gap", cyc - s_prev, 50);
    s_prev = cyc;
    repeat (64) tick();
    check("to not yet", timeout_err, 0);
    tick();
    check("to set", timeout_err, 1);
    check("to busy", busy, 1);
    wait_start(150, w);
    check("to next start gap", cyc - s_prev, 100);
    s_prev = cyc;

    // err_clr clears the flag
    repeat (5) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", timeout_err, 0);

    // Done on the last allowed RUN cycle beats the timeout
    repeat (58) tick();
    pulse_done(33);
    check("done vs to err", timeout_err, 0);
    check("done vs to valid early", lag_valid, 0);
    tick();
    check("done vs to valid", lag_valid, 1);
    check("done vs to lag", lag_out, pick(33, 11));

    // Timeout set beats a simultaneous err_clr
    wait_start(150, w);
    check("set/clr start gap", cyc - s_prev, 100);
    s_prev = cyc;
    repeat (64) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("set beats clr", timeout_err, 1);

    // Back-to-back: period 0, done the cycle after start
    period_cfg = '0;
    wait_start(150, w);
    check("b2b first gap", cyc - s_prev, 100);
    s_prev = cyc;
    tick();
    pulse_done(7);
    tick();
    check("b2b valid", lag_valid, 1);
    check("b2b lag", lag_out, pick(7, 12));
    wait_start(10, w);
    check("b2b gap START-RUN-CAPT-WAIT", cyc - s_prev, 4);
    s_prev = cyc;

    // Disarm during RUN: run completes, then IDLE
    tick();
    arm_en = 1'b0;
    tick();
    tick();
    pulse_done(9);
    tick();
    check("disarm valid", lag_valid, 1);
    check("disarm lag", lag_out, pick(9, 13));
    check("disarm busy in WAIT", busy, 1);
    tick();
    check("disarm busy idle", busy, 0);

    // Done while IDLE is ignored
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 3) begin
        xcorr_done  = 1'b1;
        lag_diff_in = LAG_W'(63);
      end else begin
        xcorr_done  = 1'b0;
        lag_diff_in = '0;
      end
      tick();
      if (xcorr_start === 1'b1 || lag_valid === 1'b1 || busy === 1'b1) seen++;
    end
    check("idle activity", seen, 0);
    check("idle lag hold", lag_out, pick(9, 13));

    // Reset during RUN
    period_cfg = PERIOD_W'(50);
    arm_en     = 1'b1;
    s_prev     = cyc;
    wait_start(10, w);
    check("rearm gap", cyc - s_prev, 3);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst busy", busy, 0);
    check("mid rst lag_out", lag_out, 0);
    check("mid rst lag_valid", lag_valid, 0);
    check("mid rst timeout_err", timeout_err, 0);
    check("mid rst xcorr_start", xcorr_start, 0);
    tick();
    rst_n  = 1'b1;
    s_prev = cyc;
    wait_start(20, w);
    check("post rst gap", cyc - s_prev, 3);
    repeat (2) tick();
    pulse_done(40);
    tick();
    check("post rst valid", lag_valid, 1);
    check("post rst lag reload", lag_out, 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
